// File: rtl/cordic_arbiter_pkg.sv
// rtl/cordic_arbiter_pkg.sv - shared FSM state type and default constants for cordic_arbiter
package cordic_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // K ~= 0.60725 in Q1.15, pre-scales the start vector so results need no gain correction
  localparam int X_INIT_DEFAULT = 19899;
  localparam int Y_INIT_DEFAULT = 0;

  // Timeout watchdog default, only meaningful when the watchdog is compiled in
  localparam int TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/cordic_arbiter_if.sv
// rtl/cordic_arbiter_if.sv - requester, response and CORDIC core signal bundle for cordic_arbiter
interface cordic_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = 16,
  parameter int ANGLE_WIDTH = 32
);

  // Requester side
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*ANGLE_WIDTH-1:0] req_angle;

  // Response side (shared data bus, per-requester valid/ready)
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [NUM_REQ-1:0]             rsp_ready;
  logic [WIDTH-1:0]               rsp_cos;
  logic [WIDTH-1:0]               rsp_sin;
  logic                           rsp_err;

  // CORDIC core side
  logic                           core_start;
  logic [WIDTH-1:0]               core_x_start;
  logic [WIDTH-1:0]               core_y_start;
  logic [ANGLE_WIDTH-1:0]         core_angle;
  logic [WIDTH-1:0]               core_cos;
  logic [WIDTH-1:0]               core_sin;
  logic                           core_done;

  // Arbiter view
  modport slave (
    input  req_valid, req_angle, rsp_ready, core_cos, core_sin, core_done,
    output req_ready, rsp_valid, rsp_cos, rsp_sin, rsp_err,
    output core_start, core_x_start, core_y_start, core_angle
  );

  // Clients plus core view
  modport master (
    output req_valid, req_angle, rsp_ready, core_cos, core_sin, core_done,
    input  req_ready, rsp_valid, rsp_cos, rsp_sin, rsp_err,
    input  core_start, core_x_start, core_y_start, core_angle
  );

endinterface

// File: rtl/cordic_arbiter_rr_picker.sv
// rtl/cordic_arbiter_rr_picker.sv - combinational round-robin picker scanning from ptr with wrap
module rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // Request vector rotated so bit 0 is the requester at ptr
  logic [NUM_REQ-1:0] rot;
  // Unwrapped winner index, one bit wider so ptr + offset cannot overflow
  logic [IDX_W:0]     sum;

  // Rotate, find the lowest set offset, then map it back to an absolute index
  always_comb begin
    rot       = '0;
    sum       = '0;
    grant     = '0;
    grant_idx = '0;
    any_valid = 1'b0;

    rot = NUM_REQ'({req, req} >> ptr);

    // Walking from the top down leaves the smallest offset as the final winner
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any_valid = 1'b1;
        sum       = {1'b0, ptr} + (IDX_W + 1)'(k);
      end
    end

    if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
      sum = sum - (IDX_W + 1)'(NUM_REQ);
    end

    grant_idx = sum[IDX_W-1:0];
    if (any_valid) begin
      grant = NUM_REQ'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// rtl/cordic_arbiter.sv - round-robin sharing of one iterative CORDIC core; optional watchdog via CORDIC_ARB_TIMEOUT_EN
module cordic_arbiter
  import cordic_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 16,
  parameter int ANGLE_WIDTH    = 32,
  parameter int X_INIT         = X_INIT_DEFAULT,
  parameter int Y_INIT         = Y_INIT_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic             clk,
  input logic             rst_n,
  cordic_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t state;
  arb_state_t state_next;

  logic [IDX_W-1:0]       ptr;          // scan start for the next arbitration
  logic [IDX_W-1:0]       g;            // requester that owns the in-flight job
  logic [ANGLE_WIDTH-1:0] angle_q;
  logic [WIDTH-1:0]       cos_q;
  logic [WIDTH-1:0]       sin_q;
  logic                   start_q;
  logic [NUM_REQ-1:0]     rsp_valid_q;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;

  logic                   accept;       // request handshake this cycle
  logic                   rsp_fire;     // response handshake this cycle
  logic                   done_hit;     // core result arriving while waiting for it
  logic                   wait_exit;    // WAIT is left this cycle, by result or by watchdog

  logic [ANGLE_WIDTH-1:0] angle_arr [NUM_REQ];

  // Unpack the flattened angle bus so the grant index can select directly
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign angle_arr[i] = bus.req_angle[i*ANGLE_WIDTH +: ANGLE_WIDTH];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req       (bus.req_valid),
    .ptr       (ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_valid (pick_any)
  );

  assign accept   = (state == IDLE) && pick_any;
  assign rsp_fire = (state == RESP) && bus.rsp_ready[g];
  assign done_hit = (state == WAIT) && bus.core_done;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;
  logic             err_q;

  // The counter reaches TIMEOUT_CYCLES on the same edge the FSM leaves WAIT
  assign timeout_hit = (state == WAIT) && !bus.core_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign wait_exit   = done_hit || timeout_hit;
  assign bus.rsp_err = err_q;

  // Cycles spent in WAIT; held at zero elsewhere so every WAIT entry starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Error flag travels with the response data: set on abort, cleared by a real result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (done_hit) begin
      err_q <= 1'b0;
    end else if (timeout_hit) begin
      err_q <= 1'b1;
    end
  end
`else
  assign wait_exit   = done_hit;
  assign bus.rsp_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the one combinational output, req_ready
  always_comb begin
    state_next    = state;
    bus.req_ready = '0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          bus.req_ready = pick_grant;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        // A done pulse here cannot belong to this job, so it is not looked at
        state_next = WAIT;
      end
      WAIT: begin
        if (wait_exit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready[g]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture grant and angle on accept; the angle then stays put until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g       <= '0;
      angle_q <= '0;
      start_q <= 1'b0;
    end else begin
      start_q <= accept;
      if (accept) begin
        g       <= pick_idx;
        angle_q <= angle_arr[pick_idx];
      end
    end
  end

  // Result capture: core data on done, zeros when the watchdog aborts the job
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cos_q <= '0;
      sin_q <= '0;
    end else if (done_hit) begin
      cos_q <= bus.core_cos;
      sin_q <= bus.core_sin;
    end else if (wait_exit) begin
      cos_q <= '0;
      sin_q <= '0;
    end
  end

  // Response valid to the owner, and pointer advance so the winner drops to lowest priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      ptr         <= '0;
    end else begin
      if (state == WAIT && wait_exit) begin
        rsp_valid_q <= NUM_REQ'(1) << g;
      end else if (rsp_fire) begin
        rsp_valid_q <= '0;
      end
      if (rsp_fire) begin
        ptr <= (g == IDX_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
      end
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_cos      = cos_q;
  assign bus.rsp_sin      = sin_q;
  assign bus.core_start   = start_q;
  assign bus.core_angle   = angle_q;
  assign bus.core_x_start = WIDTH'(X_INIT);
  assign bus.core_y_start = WIDTH'(Y_INIT);

endmodule
